// File: rtl/gpu_pixel_writer.sv
// Buffers rasteriser pixels in a small FIFO, clips off-screen ones and commits
// each remaining pixel to the framebuffer over a single-outstanding req/ack port.
module gpu_pixel_writer #(
  parameter int WIDTH_BITS  = 10,
  parameter int HEIGHT_BITS = 9,
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int ADDR_BITS   = 19,
  parameter int COLOR_BITS  = 8,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   px_valid,
  input  logic [WIDTH_BITS-1:0]  X,
  input  logic [HEIGHT_BITS-1:0] Y,
  input  logic [COLOR_BITS-1:0]  color,
  output logic                   px_ready,
  input  logic                   done_i,
  output logic                   mem_req,
  output logic [ADDR_BITS-1:0]   mem_addr,
  output logic [COLOR_BITS-1:0]  mem_wdata,
  input  logic                   mem_ack,
  output logic                   done_o,
  output logic                   idle_o,
  output logic [15:0]            drop_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]       FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [WIDTH_BITS:0]    SCR_W    = (WIDTH_BITS+1)'(SCREEN_W);
  localparam logic [HEIGHT_BITS:0]   SCR_H    = (HEIGHT_BITS+1)'(SCREEN_H);
  localparam logic [ADDR_BITS-1:0]   ROW_STEP = ADDR_BITS'(SCREEN_W);

  typedef enum logic [1:0] {IDLE, LOAD, REQ} state_e;

  state_e                 state_q;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [PTR_W-1:0]       rd_ptr_q, wr_ptr_q;
  logic [WIDTH_BITS-1:0]  fifo_x_q [FIFO_DEPTH];
  logic [HEIGHT_BITS-1:0] fifo_y_q [FIFO_DEPTH];
  logic [COLOR_BITS-1:0]  fifo_c_q [FIFO_DEPTH];
  logic                   pend_done_q;
  logic                   mem_req_q;
  logic [ADDR_BITS-1:0]   mem_addr_q;
  logic [COLOR_BITS-1:0]  mem_wdata_q;
  logic [15:0]            drop_cnt_q;

  logic                   accept, clip, push, pop, fifo_empty;
  logic [ADDR_BITS-1:0]   head_addr;

  always_comb begin
    fifo_empty = (count_q == '0);
    accept     = px_valid && px_ready;
    clip       = ({1'b0, X} >= SCR_W) || ({1'b0, Y} >= SCR_H);
    push       = accept && !clip;
    pop        = (state_q == REQ) && mem_ack;
    count_d    = count_q;
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);
    head_addr  = ADDR_BITS'(fifo_y_q[rd_ptr_q]) * ROW_STEP + ADDR_BITS'(fifo_x_q[rd_ptr_q]);
  end

  assign px_ready  = (count_q != FULL_CNT);
  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign drop_cnt  = drop_cnt_q;
  assign done_o    = pend_done_q && fifo_empty && (state_q == IDLE);
  assign idle_o    = fifo_empty && (state_q == IDLE) && !pend_done_q;

  // Pixel payload storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_x_q[wr_ptr_q] <= X;
      fifo_y_q[wr_ptr_q] <= Y;
      fifo_c_q[wr_ptr_q] <= color;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      pend_done_q <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);

      if (accept && clip && (drop_cnt_q != 16'hFFFF))
        drop_cnt_q <= drop_cnt_q + 16'd1;

      // A new done always wins so a done arriving with the done_o pulse is not lost.
      if (done_i)      pend_done_q <= 1'b1;
      else if (done_o) pend_done_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (!fifo_empty) state_q <= LOAD;
        end
        LOAD: begin
          mem_addr_q  <= head_addr;
          mem_wdata_q <= fifo_c_q[rd_ptr_q];
          mem_req_q   <= 1'b1;
          state_q     <= REQ;
        end
        REQ: begin
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            state_q   <= (count_d != '0) ? LOAD : IDLE;
          end
        end
        default: begin
          mem_req_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gpu_pixel_writer.sv
// Scoreboard bench for gpu_pixel_writer: directed pixels push expected writes,
// a monitor pops and compares each acknowledged framebuffer write.
module tb_gpu_pixel_writer;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        px_valid = 1'b0;
  logic [9:0]  X = '0;
  logic [8:0]  Y = '0;
  logic [7:0]  color = '0;
  logic        px_ready;
  logic        done_i = 1'b0;
  logic        mem_req;
  logic [18:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack = 1'b0;
  logic        done_o;
  logic        idle_o;
  logic [15:0] drop_cnt;

  typedef struct {int addr; int data;} expWrite_t;
  expWrite_t sbQueue[$];

  int testsRun = 0;
  int failures = 0;
  bit ackEn = 1'b0;
  int ackDelay = 1;
  int waitCnt = 0;

  gpu_pixel_writer dut (
    .clk(clk), .n_rst(n_rst), .px_valid(px_valid), .X(X), .Y(Y), .color(color),
    .px_ready(px_ready), .done_i(done_i), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .done_o(done_o), .idle_o(idle_o),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Presents one pixel, waits (bounded) for acceptance, returns #1 after the transfer edge.
  task automatic applyStimulus(input int x, input int y, input int c,
                               input int expAddr, input bit expectWrite);
    int guard = 0;
    expWrite_t e;
    X = 10'(x); Y = 9'(y); color = 8'(c); px_valid = 1'b1;
    while (!px_ready && guard < 200) begin
      @(posedge clk); #1; guard++;
    end
    if (guard >= 200) checkOutput("accept timeout", 32'(px_ready), 32'd1);
    if (expectWrite) begin
      e.addr = expAddr; e.data = c;
      sbQueue.push_back(e);
    end
    @(posedge clk); #1;
    px_valid = 1'b0;
  endtask

  task automatic waitIdle(input string name);
    int guard = 0;
    while (!(idle_o && sbQueue.size() == 0) && guard < 500) begin
      @(posedge clk); #1; guard++;
    end
    checkOutput({name, " idle"}, 32'(idle_o), 32'd1);
    checkOutput({name, " pending writes"}, 32'(sbQueue.size()), 32'd0);
  endtask

  // Memory responder: acks each request after ackDelay cycles when enabled.
  initial forever begin
    @(posedge clk); #1;
    if (ackEn) begin
      if (mem_ack) mem_ack = 1'b0;
      else if (mem_req) begin
        if (waitCnt >= ackDelay) begin
          mem_ack = 1'b1; waitCnt = 0;
        end else waitCnt++;
      end else waitCnt = 0;
    end
  end

  // Monitor: every acknowledged write must match the scoreboard head.
  initial forever begin
    expWrite_t e;
    @(negedge clk);
    if (n_rst && mem_req && mem_ack) begin
      if (sbQueue.size() == 0) begin
        testsRun++; failures++;
        $display("[TB] FAIL unexpected write: got addr %0d, expected no write", mem_addr);
      end else begin
        e = sbQueue.pop_front();
        checkOutput("write addr", 32'(mem_addr), 32'(e.addr));
        checkOutput("write data", 32'(mem_wdata), 32'(e.data));
      end
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int doneCount;
    int earlyDone;
    int guard;
    expWrite_t e;

    #12;
    checkOutput("reset px_ready", 32'(px_ready), 32'd1);
    checkOutput("reset mem_req", 32'(mem_req), 32'd0);
    checkOutput("reset mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("reset mem_wdata", 32'(mem_wdata), 32'd0);
    checkOutput("reset done_o", 32'(done_o), 32'd0);
    checkOutput("reset idle_o", 32'(idle_o), 32'd1);
    checkOutput("reset drop_cnt", 32'(drop_cnt), 32'd0);
    @(negedge clk); n_rst = 1'b1;
    @(posedge clk); #1;

    // Centre pixel: request appears two edges after acceptance.
    ackEn = 1'b1; ackDelay = 1;
    applyStimulus(320, 240, 8'h5A, 153920, 1'b1);
    checkOutput("latency k+0 req", 32'(mem_req), 32'd0);
    @(posedge clk); #1;
    checkOutput("latency k+1 req", 32'(mem_req), 32'd0);
    @(posedge clk); #1;
    checkOutput("latency k+2 req", 32'(mem_req), 32'd1);
    checkOutput("centre addr", 32'(mem_addr), 32'd153920);
    checkOutput("centre data", 32'(mem_wdata), 32'h5A);
    waitIdle("centre");

    // Bottom-right corner and clipped pixels.
    applyStimulus(639, 479, 8'hC3, 307199, 1'b1);
    waitIdle("corner");
    applyStimulus(640, 0, 8'h01, 0, 1'b0);
    applyStimulus(0, 480, 8'h02, 0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("clip drop_cnt", 32'(drop_cnt), 32'd2);
    checkOutput("clip px_ready", 32'(px_ready), 32'd1);
    checkOutput("clip mem_req", 32'(mem_req), 32'd0);

    // Backpressure: no acks, four accepted, fifth stalls until one ack.
    ackEn = 1'b0;
    applyStimulus(0, 0, 8'h11, 0, 1'b1);
    applyStimulus(1, 0, 8'h22, 1, 1'b1);
    applyStimulus(10, 1, 8'h33, 650, 1'b1);
    applyStimulus(5, 2, 8'h44, 1285, 1'b1);
    checkOutput("full px_ready", 32'(px_ready), 32'd0);
    X = 10'd100; Y = 9'd100; color = 8'h55; px_valid = 1'b1;
    e.addr = 64100; e.data = 8'h55;
    sbQueue.push_back(e);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("stall px_ready", 32'(px_ready), 32'd0);
    checkOutput("stall mem_req", 32'(mem_req), 32'd1);
    mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    checkOutput("after ack px_ready", 32'(px_ready), 32'd1);
    @(posedge clk); #1;
    px_valid = 1'b0;
    ackEn = 1'b1;
    waitIdle("stream");

    // Done tracking with two pixels still queued.
    ackDelay = 3;
    applyStimulus(2, 3, 8'h66, 1922, 1'b1);
    applyStimulus(4, 5, 8'h77, 3204, 1'b1);
    done_i = 1'b1;
    @(posedge clk); #1;
    done_i = 1'b0;
    checkOutput("done held", 32'(done_o), 32'd0);
    doneCount = 0; earlyDone = 0;
    repeat (40) begin
      if (done_o) begin
        doneCount++;
        if (sbQueue.size() != 0) earlyDone++;
      end
      @(posedge clk); #1;
    end
    checkOutput("done pulses", 32'(doneCount), 32'd1);
    checkOutput("done early", 32'(earlyDone), 32'd0);
    checkOutput("done idle_o", 32'(idle_o), 32'd1);

    // Asynchronous reset while a request is outstanding.
    ackEn = 1'b0; ackDelay = 1;
    applyStimulus(7, 7, 8'h81, 4487, 1'b1);
    applyStimulus(8, 8, 8'h82, 5128, 1'b1);
    applyStimulus(9, 9, 8'h83, 5769, 1'b1);
    guard = 0;
    while (!mem_req && guard < 20) begin
      @(posedge clk); #1; guard++;
    end
    checkOutput("pre-reset mem_req", 32'(mem_req), 32'd1);
    #2 n_rst = 1'b0;
    #1;
    checkOutput("async reset mem_req", 32'(mem_req), 32'd0);
    checkOutput("async reset drop_cnt", 32'(drop_cnt), 32'd0);
    sbQueue.delete();
    @(negedge clk); n_rst = 1'b1;
    @(posedge clk); #1;
    ackEn = 1'b1;
    guard = 0;
    repeat (10) begin
      if (mem_req) guard++;
      @(posedge clk); #1;
    end
    checkOutput("post-reset requests", 32'(guard), 32'd0);
    checkOutput("post-reset idle_o", 32'(idle_o), 32'd1);
    checkOutput("post-reset px_ready", 32'(px_ready), 32'd1);

    // Drop counter saturation.
    X = 10'd1023; Y = 9'd0; color = 8'hEE; px_valid = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    checkOutput("drop_cnt 100", 32'(drop_cnt), 32'd100);
    repeat (69900) @(posedge clk);
    #1;
    px_valid = 1'b0;
    checkOutput("drop_cnt saturated", 32'(drop_cnt), 32'd65535);
    checkOutput("saturate mem_req", 32'(mem_req), 32'd0);
    checkOutput("saturate idle_o", 32'(idle_o), 32'd1);

    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule

// File: doc/gpu_pixel_writer.md
Name: gpu_pixel_writer

Overview:
Consumes the pixel-coordinate stream produced by the GPU primitive rasterisers (octant/circle/line drawers) and commits each pixel to framebuffer memory. Buffers incoming (X,Y,color) in a small FIFO so a drawer can run ahead of memory latency. Clips off-screen pixels and converts each coordinate to a linear framebuffer address. Drives a single-outstanding req/ack write port. Sits between the drawer engines and the framebuffer arbiter.

Parameters:
WIDTH_BITS, 10, X coordinate width (matches gpu_definitions.vh)
HEIGHT_BITS, 9, Y coordinate width (matches gpu_definitions.vh)
SCREEN_W, 640, visible width in pixels
SCREEN_H, 480, visible height in pixels
ADDR_BITS, 19, framebuffer word address width
COLOR_BITS, 8, pixel data width
FIFO_DEPTH, 4, pixel buffer entries; power of 2, at least 2

Ports:
clk  in  1  system clock, rising edge
n_rst  in  1  asynchronous active-low reset
px_valid  in  1  drawer presents a pixel this cycle (drawer's busy_o)
X  in  WIDTH_BITS  pixel column
Y  in  HEIGHT_BITS  pixel row
color  in  COLOR_BITS  pixel value
px_ready  out  1  writer can accept a pixel this cycle
done_i  in  1  one-cycle pulse: drawer finished its primitive
mem_req  out  1  write request to framebuffer
mem_addr  out  ADDR_BITS  write address, Y*SCREEN_W+X
mem_wdata  out  COLOR_BITS  write data
mem_ack  in  1  one-cycle acceptance of current request
done_o  out  1  one-cycle pulse: all pixels of finished primitive committed
idle_o  out  1  FIFO empty, FSM in IDLE, no pending done
drop_cnt  out  16  count of clipped pixels, saturating

Behaviour:
- Reset (async, n_rst=0): FIFO empty, FSM=IDLE, pend_done=0, drop_cnt=0. Outputs: px_ready=1, mem_req=0, mem_addr=0, mem_wdata=0, done_o=0, idle_o=1. Reset mid-request drops mem_req immediately; the in-flight pixel is discarded.
- Input handshake: transfer when px_valid && px_ready at a rising edge. px_ready = !fifo_full (registered-count based; no combinational path from mem_ack).
- Clipping: X>=SCREEN_W or Y>=SCREEN_H: pixel is consumed (handshake completes) but not pushed; drop_cnt increments, saturates at 16'hFFFF.
- FIFO: push and pop in the same cycle permitted; count unchanged. Pop occurs only on mem_ack in REQ.
- FSM states:
  IDLE: if FIFO non-empty -> LOAD.
  LOAD: register mem_addr = Y*SCREEN_W + X (ADDR_BITS, no overflow for in-bounds pixels) and mem_wdata from FIFO head -> REQ.
  REQ: mem_req=1; mem_addr/mem_wdata held stable until mem_ack. On mem_ack: pop; if FIFO still holds another entry -> LOAD, else -> IDLE.
- mem_ack outside REQ is ignored.
- Latency: pixel accepted at edge k into an empty FIFO with FSM IDLE -> mem_req high after edge k+2. Back-to-back throughput: one write per 2 cycles plus ack wait.
- Done tracking: done_i sets pend_done (sticky). A done_i coinciding with the final pixel transfer counts after that pixel. done_o pulses for exactly one cycle on the first cycle where pend_done=1, FIFO empty, and FSM=IDLE; pend_done clears on that same edge. A second done_i while pend_done=1 is merged into the pending done.
- idle_o = FIFO empty && FSM=IDLE && !pend_done.

Test Plan:
- Reset, then push (320,240,color=8'h5A) with mem_ack returned 1 cycle after req -> mem_req high 2 cycles after accept; mem_addr=153920, mem_wdata=8'h5A; idle_o returns to 1.
- Push (639,479) -> mem_addr=307199. Push (640,0), then (0,480) -> neither produces a request; drop_cnt=2; px_ready stays 1.
- Hold mem_ack=0, stream 5 pixels -> px_ready low after 4th accept, 5th stalls. Pulse mem_ack -> px_ready high next cycle; all 5 written in order with correct addresses.
- Push 2 pixels, pulse done_i with both still queued -> done_o stays 0 until second mem_ack; then exactly one done_o pulse and idle_o=1.
- Assert n_rst=0 while mem_req=1 with 3 queued -> mem_req=0 immediately; after release: FIFO empty, drop_cnt=0, no further requests.
- Drive 70000 off-screen pixels -> drop_cnt saturates at 65535.
